tppe_accumulator: RTL
=====================

# tppe_accumulator

Upstream feeder for the LIF stage. It accepts a stream of (spike-vector, weight) beats for one output neuron and accumulates the weight into one of T per-timestep partial sums for every timestep whose input spike is set. On the neuron's last beat it presents the T packed Q-bit sums on `result_data` with `result_val`, and holds them until the LIF stage acknowledges completion.

## Interface
Parameters:
- `T`, 4: timesteps per neuron; also the width of the spike vector.
- `Q`, 10: bits per accumulated timestep sum; must match the LIF stage.
- `W`, 8: weight width, unsigned; W <= Q is required.
- `N`, 16: maximum beats per neuron; N >= 2.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous active-high reset.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  block can accept a beat.
- `in_spikes`  in  T  bit t set means input spiked at timestep t.
- `in_weight`  in  W  synaptic weight, unsigned.
- `in_last`  in  1  final beat of the current neuron.
- `result_data`  out  T*Q  slot t occupies bits `[(t+1)*Q-1 -: Q]`.
- `result_val`  out  1  `result_data` is valid and stable.
- `result_ack`  in  1  consumer is finished with the result; driven by the LIF `lif_done`.
- `beat_cnt`  out  $clog2(N+1)  number of beats accepted for the current neuron.
- `ovf_err`  out  1  sticky flag: a neuron was force-closed at N beats without `in_last`.

## Operation
- States:
  - ACCUM (the reset state).
  - HOLD.
- `in_ready = (state == ACCUM)`. This is combinational from state only.
- A beat is accepted when `in_valid & in_ready`.
- On each accepted beat, for every t with `in_spikes[t] == 1`:
  - `acc[t] <= sat(acc[t] + zext(in_weight))`.
  - The sum is formed at Q+1 bits and clamps to 2^Q-1 on overflow.
  - Slots with `in_spikes[t] == 0` are unchanged.
- `beat_cnt` increments on each accepted beat.
- Closing a neuron: an accepted beat closes the neuron if `in_last == 1` or `beat_cnt == N-1`.
  - `result_data` is loaded with the updated sums, i.e. the closing beat is included.
  - `result_val` goes to 1 and the state goes to HOLD.
  - Forced close (`beat_cnt == N-1` and `in_last == 0`) also sets `ovf_err`.
- HOLD:
  - `result_data` and `result_val` are held stable.
  - Inputs are not accepted.
  - When `result_ack == 1`: `result_val` goes to 0, all `acc` slots, `beat_cnt` and `result_data` go to 0, and the state returns to ACCUM.
- `result_ack` is ignored in ACCUM.
- `ovf_err` is cleared only by `rst`.
- A neuron with zero spikes across all beats yields `result_data == 0` with `result_val` asserted as normal.

## Timing
- Reset values (after a `rst` edge):
  - `in_ready = 1`.
  - `result_val = 0`.
  - `result_data = 0`.
  - `beat_cnt = 0`.
  - `ovf_err = 0`.
  - All `acc` slots 0.
  - State ACCUM.
- Throughput: one beat per cycle while in ACCUM.
- Latency: closing beat accepted at edge k gives `result_val = 1` and valid `result_data` after edge k. `in_ready` is 0 in the cycle after edge k.
- Release: `result_ack` sampled high at edge m gives `result_val = 0` and `in_ready = 1` after edge m. The next beat can be accepted at edge m+1.
- Minimum neuron period: beats + 1 cycle (the ack cycle), assuming same-cycle ack.
- `result_ack` held high for several cycles has no effect beyond the first.
- `in_valid` while `in_ready == 0`: the beat is not consumed. The upstream holds it.
- `rst` mid-neuron or in HOLD:
  - The partial sums are discarded and `result_val` drops after the edge.
  - A result in flight is lost and the consumer must not ack it.
- `rst` has priority over every other event in the same cycle.

## Test plan
- Basic accumulation:
  - Stimulus: beats (spikes=4'b0101, w=10), (4'b0011, w=20), (4'b1000, w=7, last).
  - Required response: slots t0..t3 = 30, 20, 10, 7, i.e. `result_data = {10'd7, 10'd10, 10'd20, 10'd30}`.
  - `result_val` is high the cycle after the last beat.
  - `beat_cnt = 3`.
- Saturation: 5 beats of (4'b1111, w=255), last on the 5th.
  - Required response: every slot equals 1023.
  - `ovf_err` stays 0.
- Forced close with N=16: 16 beats of (4'b0001, w=1) with `in_last` never set.
  - Required response: closes on the 16th beat with slot0 = 16 and other slots 0.
  - `ovf_err = 1` and remains 1 through later neurons until `rst`.
- Backpressure and hold:
  - Stimulus: hold `result_ack` low for 5 cycles while `in_valid = 1`.
  - Required response: `in_ready = 0`, `result_data` unchanged and no beat consumed.
  - Then pulse ack: `result_val` drops next cycle and the following beat is accepted one cycle later into zeroed sums.
- Back-to-back neurons with same-cycle ack:
  - Stimulus: two single-beat neurons (4'b1111, w=3) then (4'b0000, w=9), ack on the first HOLD cycle.
  - Required response: results 4x3 then all-zero, with exactly 1 bubble cycle between them.
- Reset mid-operation:
  - Stimulus: `rst` after 2 beats of the first neuron, then a new neuron with a single last beat (4'b0010, w=5).
  - Required response: the result is slot1 = 5 only, with no residue from the first neuron.
  - `rst` asserted during HOLD drops `result_val` the next cycle.

Source files
------------

// File: rtl/tppe_accumulator_if.sv
// Beat stream and result handshake between feeder, accumulator and LIF stage.
interface tppe_accumulator_if #(
    parameter int unsigned T = 4,
    parameter int unsigned Q = 10,
    parameter int unsigned W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [T-1:0]     in_spikes;
    logic [W-1:0]     in_weight;
    logic             in_last;
    logic [T*Q-1:0]   result_data;
    logic             result_val;
    logic             result_ack;

    // Upstream feeder / LIF side.
    modport master (
        output in_valid, in_spikes, in_weight, in_last, result_ack,
        input  in_ready, result_data, result_val
    );

    // Accumulator side.
    modport slave (
        input  in_valid, in_spikes, in_weight, in_last, result_ack,
        output in_ready, result_data, result_val
    );
endinterface

// File: rtl/tppe_accumulator.sv
// Per-timestep saturating weight accumulator feeding the LIF stage.
// Interface parameters T/Q/W must match the module parameters.
module tppe_accumulator #(
    parameter int unsigned T = 4,
    parameter int unsigned Q = 10,
    parameter int unsigned W = 8,
    parameter int unsigned N = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    tppe_accumulator_if.slave        bus,
    output logic [$clog2(N+1)-1:0]   beat_cnt,
    output logic                     ovf_err
);
    localparam int unsigned CW = $clog2(N+1);

    typedef enum logic [0:0] {ACCUM, HOLD} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [T-1:0][Q-1:0]  acc;
    logic [T-1:0][Q-1:0]  acc_upd;
    logic [T-1:0][Q-1:0]  result_q;
    logic                 result_val_q;
    logic [Q:0]           sum;
    logic                 accept;
    logic                 last_slot;
    logic                 close;
    logic                 force_close;
    logic                 release_hold;

    assign bus.in_ready    = (state == ACCUM);
    assign bus.result_data = result_q;
    assign bus.result_val  = result_val_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, beat acceptance and saturating slot updates.
    always_comb begin
        state_nxt    = state;
        acc_upd      = acc;
        sum          = '0;
        accept       = bus.in_valid && (state == ACCUM);
        last_slot    = (beat_cnt == CW'(N - 1));
        close        = accept && (bus.in_last || last_slot);
        force_close  = accept && last_slot && !bus.in_last;
        release_hold = (state == HOLD) && bus.result_ack;

        for (int t = 0; t < int'(T); t++) begin
            sum = {1'b0, acc[t]} + (Q+1)'(bus.in_weight);
            if (accept && bus.in_spikes[t]) begin
                acc_upd[t] = sum[Q] ? {Q{1'b1}} : sum[Q-1:0];
            end
        end

        case (state)
            ACCUM:   if (close) state_nxt = HOLD;
            HOLD:    if (bus.result_ack) state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    // Accumulators, beat counter, result register and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc          <= '0;
            beat_cnt     <= '0;
            result_q     <= '0;
            result_val_q <= 1'b0;
            ovf_err      <= 1'b0;
        end else if (release_hold) begin
            acc          <= '0;
            beat_cnt     <= '0;
            result_q     <= '0;
            result_val_q <= 1'b0;
        end else if (accept) begin
            acc      <= acc_upd;
            beat_cnt <= beat_cnt + CW'(1);
            if (close) begin
                result_q     <= acc_upd;
                result_val_q <= 1'b1;
            end
            if (force_close) begin
                ovf_err <= 1'b1;
            end
        end
    end
endmodule
